// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types for the FIFO packet reader: frame-bit offsets, reader FSM states
// and the per-beat framing flags carried alongside the payload.
package fifo_pkt_reader_pkg;

  // sop/eop positions in a FIFO word, relative to DATA_W
  localparam int SOP_BIT = 1;
  localparam int EOP_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
  } beat_flags_t;

  function automatic beat_flags_t mk_flags(input logic sop, input logic eop, input logic err);
    beat_flags_t f;
    f.sop = sop;
    f.eop = eop;
    f.err = err;
    return f;
  endfunction

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FIFO-head and framed beat-stream signals of the packet reader.
// master = the reader, slave = FIFO plus downstream parser.
interface fifo_pkt_reader_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W+1:0] fifo_q;
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_err;

  modport master (
    input  fifo_q, fifo_empty, out_ready,
    output fifo_rdreq, out_valid, out_data, out_sop, out_eop, out_err
  );

  modport slave (
    output fifo_q, fifo_empty, out_ready,
    input  fifo_rdreq, out_valid, out_data, out_sop, out_eop, out_err
  );
endinterface

// File: rtl/pkt_out_skid.sv
// Two-entry valid/ready skid buffer with registered outputs. The writer must only
// push while occ_o < 2, which lets it decide without looking at out_ready_i.
module pkt_out_skid #(
  parameter int WIDTH = 35
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occ_o
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q;
  logic             pop;

  assign pop = valid_q & out_ready_i;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      2'd0: begin
        if (in_valid_i) begin
          head_d = in_data_i;
          occ_d  = 2'd1;
        end else begin
          occ_d = 2'd0;
        end
      end
      2'd1: begin
        // push with pop replaces the head directly, keeping order and occupancy
        if (in_valid_i && pop) begin
          head_d = in_data_i;
        end else if (in_valid_i) begin
          tail_d = in_data_i;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end else begin
          occ_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end else begin
          occ_d = 2'd2;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (occ_d != 2'd0);
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a show-ahead FIFO into a framed beat stream: discards out-of-packet words,
// truncates oversize packets, closes unterminated ones; counts packets and drops.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              aclr,
  fifo_pkt_reader_if.master bus,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int BEAT_CW = $clog2(MAX_WORDS + 1);
  localparam logic [BEAT_CW-1:0] LAST_IDX = BEAT_CW'(MAX_WORDS - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    beat_flags_t       flags;
  } beat_t;

  rd_state_t         state_q, state_d;
  logic [BEAT_CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              head_sop, head_eop, have_word, has_room, hold_sop;
  logic              pop, push, drop;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        occ;
  logic              skid_valid;
  beat_t             push_beat, out_beat;

  assign head_sop  = bus.fifo_q[DATA_W+SOP_BIT];
  assign head_eop  = bus.fifo_q[DATA_W+EOP_BIT];
  assign head_data = bus.fifo_q[DATA_W-1:0];
  assign have_word = ~bus.fifo_empty;
  assign has_room  = (occ != 2'd2);
  // a sop at the head while a packet is open or being dropped is left for IDLE
  assign hold_sop  = have_word & head_sop & (state_q != IDLE);
  assign pop       = have_word & has_room & ~hold_sop;
  assign bus.fifo_rdreq = pop;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    push            = 1'b0;
    drop            = 1'b0;
    push_beat.data  = head_data;
    push_beat.flags = mk_flags(1'b0, 1'b0, 1'b0);
    case (state_q)
      IDLE: begin
        if (pop && head_sop) begin
          push            = 1'b1;
          push_beat.flags = mk_flags(1'b1, head_eop, 1'b0);
          if (!head_eop) begin
            state_d = PKT;
            cnt_d   = BEAT_CW'(1);
          end else begin
            state_d = IDLE;
          end
        end else if (pop) begin
          drop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PKT: begin
        if (hold_sop) begin
          if (has_room) begin
            push            = 1'b1;
            push_beat.data  = '0;
            push_beat.flags = mk_flags(1'b0, 1'b1, 1'b1);
            state_d         = IDLE;
          end else begin
            state_d = PKT;
          end
        end else if (pop) begin
          push = 1'b1;
          if (head_eop) begin
            push_beat.flags = mk_flags(1'b0, 1'b1, 1'b0);
            state_d         = IDLE;
          end else if (cnt_q == LAST_IDX) begin
            push_beat.flags = mk_flags(1'b0, 1'b1, 1'b1);
            state_d         = DROP;
          end else begin
            cnt_d = cnt_q + BEAT_CW'(1);
          end
        end else begin
          state_d = PKT;
        end
      end
      DROP: begin
        if (hold_sop) begin
          state_d = IDLE;
        end else if (pop) begin
          drop    = 1'b1;
          state_d = head_eop ? IDLE : DROP;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (push && push_beat.flags.eop) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  pkt_out_skid #(
    .WIDTH(DATA_W + 3)
  ) u_skid (
    .clock       (clock),
    .aclr        (aclr),
    .in_valid_i  (push),
    .in_data_i   (push_beat),
    .out_ready_i (bus.out_ready),
    .out_valid_o (skid_valid),
    .out_data_o  (out_beat),
    .occ_o       (occ)
  );

  assign bus.out_valid = skid_valid;
  assign bus.out_data  = out_beat.data;
  assign bus.out_sop   = out_beat.flags.sop;
  assign bus.out_eop   = out_beat.flags.eop;
  assign bus.out_err   = out_beat.flags.err;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: queue-backed show-ahead FIFO, word-level framing model
// feeding a scoreboard, and an independent monitor comparing every presented beat.
module tb_fifo_pkt_reader;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          aclr  = 1'b1;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  fifo_pkt_reader_if #(.DATA_W(DW)) bus ();

  fifo_pkt_reader #(.DATA_W(DW), .MAX_WORDS(MW), .CNT_W(CW)) dut (
    .clock      (clock),
    .aclr       (aclr),
    .bus        (bus),
    .pkt_cnt_o  (pkt_cnt),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          err;
  } exp_t;

  logic [DW+1:0] mem[$];
  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            pop_count = 0;
  bit            rd_seen;
  bit            m_open, m_drop;
  int            m_len, exp_pkt, exp_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW+1:0] mkw(input bit s, input bit e, input logic [DW-1:0] d);
    return {s, e, d};
  endfunction

  function automatic void emit(input logic [DW-1:0] d, input bit s, input bit e, input bit r);
    exp_t b;
    b.data = d; b.sop = s; b.eop = e; b.err = r;
    exp_q.push_back(b);
    if (e) exp_pkt++;
  endfunction

  // Framing rules applied word by word in FIFO order
  function automatic void model_word(input logic [DW+1:0] w);
    bit s = w[DW+1];
    bit e = w[DW];
    logic [DW-1:0] d = w[DW-1:0];
    if (s && m_open) begin
      emit('0, 1'b0, 1'b1, 1'b1);
      m_open = 1'b0;
    end
    if (s) m_drop = 1'b0;
    if (m_drop) begin
      exp_drop++;
      if (e) m_drop = 1'b0;
    end else if (!m_open) begin
      if (!s) exp_drop++;
      else begin
        emit(d, 1'b1, e, 1'b0);
        if (!e) begin m_open = 1'b1; m_len = 1; end
      end
    end else begin
      m_len++;
      if (e) begin
        emit(d, 1'b0, 1'b1, 1'b0); m_open = 1'b0;
      end else if (m_len == MW) begin
        emit(d, 1'b0, 1'b1, 1'b1); m_open = 1'b0; m_drop = 1'b1;
      end else begin
        emit(d, 1'b0, 1'b0, 1'b0);
      end
    end
  endfunction

  task automatic push(input logic [DW+1:0] w);
    mem.push_back(w);
    model_word(w);
  endtask

  task automatic present();
    bus.fifo_empty = (mem.size() == 0);
    bus.fifo_q     = (mem.size() != 0) ? mem[0] : '0;
  endtask

  // Show-ahead FIFO: head presented after negedge, pop applied after posedge
  initial begin
    forever begin
      @(negedge clock);
      #1 present();
      #3 rd_seen = bus.fifo_rdreq && !aclr;
      @(posedge clock);
      #1;
      if (rd_seen) begin
        if (mem.size() == 0) check("pop_on_empty", 64'(mem.size()), 64'd1);
        else begin
          void'(mem.pop_front());
          pop_count++;
        end
      end
    end
  end

  // Monitor: every presented beat must equal the scoreboard head
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!aclr && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with nothing expected at %0t", bus.out_data, $time);
        end else begin
          check("beat", 64'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_err}), 64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic quiesce(input string tag);
    int n = 0;
    @(negedge clock);
    bus.out_ready = 1'b1;
    while ((mem.size() != 0 || exp_q.size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_drain"}, 64'(n < 400), 64'd1);
    @(negedge clock);
    #3;
    check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt % (1 << CW)));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop % (1 << CW)));
  endtask

  initial begin
    logic [3:0] vld;
    int snap;
    bus.fifo_q = '0; bus.fifo_empty = 1'b1; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outs", 64'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_err}), 64'd0);
    check("rst_cnts", 64'({pkt_cnt, drop_cnt}), 64'd0);
    check("rst_rdreq", 64'(bus.fifo_rdreq), 64'd0);

    // Three-beat packet at full rate
    @(negedge clock);
    aclr = 1'b0;
    bus.out_ready = 1'b1;
    push(mkw(1, 0, 32'hA0A0_0001)); push(mkw(0, 0, 32'hB0B0_0002)); push(mkw(0, 1, 32'hC0C0_0003));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #3 vld[k] = bus.out_valid;
    end
    check("t1_valid_pattern", 64'(vld), 64'b0111);
    quiesce("t1");

    // Back-pressure: only two pops, head held
    @(negedge clock);
    bus.out_ready = 1'b0;
    snap = pop_count;
    push(mkw(1, 0, 32'h1111_AAAA)); push(mkw(0, 0, 32'h2222_BBBB)); push(mkw(0, 1, 32'h3333_CCCC));
    repeat (6) @(negedge clock);
    #3;
    check("t2_pops", 64'(pop_count - snap), 64'd2);
    check("t2_head_held", 64'({bus.out_valid, bus.out_sop, bus.out_data}), {31'd0, 1'b1, 1'b1, 32'h1111_AAAA});
    quiesce("t2");

    // Words outside a packet, then single-beat packet
    @(negedge clock);
    push(mkw(0, 0, 32'h0000_00F1)); push(mkw(0, 1, 32'h0000_00F2)); push(mkw(1, 1, 32'h0000_2222));
    quiesce("t3");

    // Single word into empty buffer -> valid next cycle
    @(negedge clock);
    push(mkw(1, 1, 32'h5A5A_5A5A));
    @(negedge clock);
    #3 check("latency", 64'(bus.out_valid), 64'd1);
    quiesce("lat");

    // Oversize packet truncated at MW beats
    @(negedge clock);
    push(mkw(1, 0, 32'd1));
    for (int i = 2; i <= 5; i++) push(mkw(0, 0, 32'(i)));
    push(mkw(0, 1, 32'd6));
    quiesce("t4");

    // Unterminated packet closed by a following sop
    @(negedge clock);
    push(mkw(1, 0, 32'hAAAA_0000)); push(mkw(0, 0, 32'hBBBB_0000));
    push(mkw(1, 0, 32'hCCCC_0000)); push(mkw(0, 1, 32'hDDDD_0000));
    quiesce("t5");

    // Asynchronous clear with two beats buffered
    @(negedge clock);
    bus.out_ready = 1'b0;
    push(mkw(0, 0, 32'h0BAD_0BAD)); push(mkw(1, 0, 32'h1234_0001));
    push(mkw(0, 0, 32'h1234_0002)); push(mkw(0, 0, 32'h1234_0003));
    repeat (5) @(negedge clock);
    #3 aclr = 1'b1;
    #1;
    check("aclr_valid", 64'(bus.out_valid), 64'd0);
    check("aclr_cnts", 64'({pkt_cnt, drop_cnt}), 64'd0);
    mem.delete(); exp_q.delete();
    m_open = 1'b0; m_drop = 1'b0; m_len = 0; exp_pkt = 0; exp_drop = 0;
    repeat (2) @(negedge clock);
    aclr = 1'b0;
    push(mkw(1, 0, 32'h7777_0001)); push(mkw(0, 1, 32'h7777_0002));
    quiesce("t6");

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (mem.size() < 8) begin
        int nw = $urandom_range(0, 2);
        for (int j = 0; j < nw; j++)
          push(mkw($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom));
      end
    end
    quiesce("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
